// File: rtl/cfg_pkg.sv
// Shared definitions for the serial configuration-chain loader.
// Contents:
//   cfg_state_t  - loader state encoding (CFG_IDLE, CFG_LOAD, CFG_VERIFY, CFG_DONE)
//   CRC16_POLY   - CRC-16-CCITT generator polynomial
//   CRC16_INIT   - CRC-16-CCITT preset value
//   crc16_step   - advances a CRC-16-CCITT register by one serial bit
package cfg_pkg;

    typedef enum logic [1:0] {
        CFG_IDLE   = 2'd0,
        CFG_LOAD   = 2'd1,
        CFG_VERIFY = 2'd2,
        CFG_DONE   = 2'd3
    } cfg_state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // MSB-first serial CRC: feedback is the outgoing MSB xor the new bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/cfg_crc16.sv
// Serial CRC-16-CCITT accumulator, one bit per clock. Only built when the
// readback-verify feature (CONFIG_LOADER_VERIFY_EN) is enabled.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset (register cleared to zero)
//   clr      - synchronous preset to CRC16_INIT (wins over en)
//   en       - absorb din this cycle
//   din      - serial data bit
//   crc      - current CRC register
//   crc_next - value the register takes at the next edge
`ifdef CONFIG_LOADER_VERIFY_EN
module cfg_crc16
    import cfg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc,
    output logic [15:0] crc_next
);

    logic [15:0] crc_r;
    logic [15:0] crc_next_s;

    // Next-state selection: preset, absorb one bit, or hold.
    always_comb begin
        crc_next_s = crc_r;
        if (clr) begin
            crc_next_s = CRC16_INIT;
        end else if (en) begin
            crc_next_s = crc16_step(crc_r, din);
        end else begin
            crc_next_s = crc_r;
        end
    end

    // CRC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_r <= 16'h0000;
        end else begin
            crc_r <= crc_next_s;
        end
    end

    assign crc      = crc_r;
    assign crc_next = crc_next_s;

endmodule
`endif

// File: rtl/config_loader.sv
// Serial configuration-chain driver. Accepts host words over valid/ready,
// shifts exactly CHAIN_LEN bits MSB-first into the chain head, then reports
// completion. Word acceptance overlaps the last bit of the previous word so a
// continuously valid host yields an unbroken config_en burst.
// Optional build macro CONFIG_LOADER_VERIFY_EN: after loading, recirculate the
// chain once through chain_tail_in (restoring it) and compare CRCs of the
// loaded and read-back streams; a difference raises error.
// Ports:
//   config_clk, config_rst_n - clock and asynchronous active-low reset
//   start                    - begin a load (honoured in IDLE/DONE only)
//   word_in/word_valid/word_ready - host word handshake
//   cfg_data, config_en      - chain head data and shared shift enable
//   chain_tail_in            - chain tail (used only with the verify macro)
//   busy, done, error        - status
module config_loader
    import cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 16,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              config_clk,
    input  logic              config_rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cfg_data,
    output logic              config_en,
    input  logic              chain_tail_in,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int SRC_W = $clog2(WORD_W + 1);

    cfg_state_t        state_r;
    logic [WORD_W-1:0] sr_r;
    logic [SRC_W-1:0]  sr_cnt_r;
    logic [CNT_W-1:0]  bits_sent_r;

    logic              shift_s;
    logic              ready_s;
    logic              accept_s;
    logic              start_ok_s;
    logic              last_shift_s;
    logic [31:0]       committed_s;
    logic [31:0]       bits_after_s;
    logic [31:0]       remain_s;
    logic [SRC_W-1:0]  load_cnt_s;
    logic              cfg_data_s;
    logic              en_s;

`ifdef CONFIG_LOADER_VERIFY_EN
    logic [CNT_W-1:0]  verify_cnt_r;
    logic              error_r;
    logic [15:0]       load_crc_s;
    logic [15:0]       load_crc_next_unused_s;
    logic [15:0]       rb_crc_unused_s;
    logic [15:0]       rb_crc_next_s;
`else
    logic              tail_unused_s;
    assign tail_unused_s = chain_tail_in;
`endif

    // Load-phase bookkeeping: shift decision, handshake and next word length.
    always_comb begin
        shift_s      = (state_r == CFG_LOAD) && (sr_cnt_r != {SRC_W{1'b0}});
        committed_s  = 32'(bits_sent_r) + 32'(sr_cnt_r);
        bits_after_s = 32'(bits_sent_r) + (shift_s ? 32'd1 : 32'd0);
        // Ready while the last held bit is going out, so the next word lands
        // without a bubble; never once every chain bit is already committed.
        ready_s      = (state_r == CFG_LOAD) && (32'(sr_cnt_r) <= 32'd1) &&
                       (committed_s < 32'(CHAIN_LEN));
        accept_s     = word_valid && ready_s;
        remain_s     = 32'(CHAIN_LEN) - bits_after_s;
        // A short final word keeps only its top bits; the rest is dropped.
        if (remain_s < 32'(WORD_W)) begin
            load_cnt_s = SRC_W'(remain_s);
        end else begin
            load_cnt_s = SRC_W'(WORD_W);
        end
        last_shift_s = shift_s && (bits_after_s == 32'(CHAIN_LEN));
        start_ok_s   = start && ((state_r == CFG_IDLE) || (state_r == CFG_DONE));
    end

    // Chain-facing outputs decoded from the current state.
    always_comb begin
        cfg_data_s = 1'b0;
        en_s       = 1'b0;
        case (state_r)
            CFG_LOAD: begin
                cfg_data_s = sr_r[WORD_W-1];
                en_s       = shift_s;
            end
`ifdef CONFIG_LOADER_VERIFY_EN
            CFG_VERIFY: begin
                cfg_data_s = chain_tail_in;
                en_s       = 1'b1;
            end
`endif
            default: begin
                cfg_data_s = 1'b0;
                en_s       = 1'b0;
            end
        endcase
    end

    // Loader state machine, holding register and counters.
    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) begin
            state_r      <= CFG_IDLE;
            sr_r         <= {WORD_W{1'b0}};
            sr_cnt_r     <= {SRC_W{1'b0}};
            bits_sent_r  <= {CNT_W{1'b0}};
`ifdef CONFIG_LOADER_VERIFY_EN
            verify_cnt_r <= {CNT_W{1'b0}};
            error_r      <= 1'b0;
`endif
        end else begin
            case (state_r)
                CFG_IDLE, CFG_DONE: begin
                    if (start_ok_s) begin
                        state_r      <= CFG_LOAD;
                        sr_cnt_r     <= {SRC_W{1'b0}};
                        bits_sent_r  <= {CNT_W{1'b0}};
`ifdef CONFIG_LOADER_VERIFY_EN
                        verify_cnt_r <= {CNT_W{1'b0}};
                        error_r      <= 1'b0;
`endif
                    end
                end
                CFG_LOAD: begin
                    if (accept_s) begin
                        sr_r     <= word_in;
                        sr_cnt_r <= load_cnt_s;
                    end else if (shift_s) begin
                        sr_r     <= sr_r << 1;
                        sr_cnt_r <= sr_cnt_r - SRC_W'(1);
                    end
                    bits_sent_r <= CNT_W'(bits_after_s);
                    if (last_shift_s) begin
`ifdef CONFIG_LOADER_VERIFY_EN
                        state_r <= CFG_VERIFY;
`else
                        state_r <= CFG_DONE;
`endif
                    end
                end
`ifdef CONFIG_LOADER_VERIFY_EN
                CFG_VERIFY: begin
                    verify_cnt_r <= verify_cnt_r + CNT_W'(1);
                    if (verify_cnt_r == CNT_W'(CHAIN_LEN - 1)) begin
                        state_r <= CFG_DONE;
                        // Include the bit absorbed on this final edge.
                        error_r <= (load_crc_s != rb_crc_next_s);
                    end
                end
`endif
                default: begin
                    state_r <= CFG_IDLE;
                end
            endcase
        end
    end

`ifdef CONFIG_LOADER_VERIFY_EN
    cfg_crc16 u_load_crc (
        .clk      (config_clk),
        .rst_n    (config_rst_n),
        .clr      (start_ok_s),
        .en       (shift_s),
        .din      (sr_r[WORD_W-1]),
        .crc      (load_crc_s),
        .crc_next (load_crc_next_unused_s)
    );

    cfg_crc16 u_rb_crc (
        .clk      (config_clk),
        .rst_n    (config_rst_n),
        .clr      (start_ok_s),
        .en       (state_r == CFG_VERIFY),
        .din      (chain_tail_in),
        .crc      (rb_crc_unused_s),
        .crc_next (rb_crc_next_s)
    );

    assign error = error_r;
`else
    assign error = 1'b0;
`endif

    assign word_ready = ready_s;
    assign cfg_data   = cfg_data_s;
    assign config_en  = en_s;
    assign busy       = (state_r == CFG_LOAD) || (state_r == CFG_VERIFY);
    assign done       = (state_r == CFG_DONE);

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: two instances (16-bit and 12-bit chains) share one
// host stimulus. Each chain is modelled as a plain shift register; the bit
// stream on cfg_data/config_en is captured and compared against the host words
// concatenated MSB-first and truncated to the chain length.
module tb_config_loader;

`ifdef CONFIG_LOADER_VERIFY_EN
    localparam int VER = 1;
`else
    localparam int VER = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       word_valid = 1'b0;
    logic [7:0] word_in = 8'h00;

    logic word_ready_a, cfg_data_a, config_en_a, busy_a, done_a, error_a, tail_a;
    logic word_ready_b, cfg_data_b, config_en_b, busy_b, done_b, error_b, tail_b;

    always #5 clk = ~clk;

    config_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut_a (
        .config_clk(clk), .config_rst_n(rst_n), .start(start),
        .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready_a),
        .cfg_data(cfg_data_a), .config_en(config_en_a), .chain_tail_in(tail_a),
        .busy(busy_a), .done(done_a), .error(error_a)
    );

    config_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut_b (
        .config_clk(clk), .config_rst_n(rst_n), .start(start),
        .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready_b),
        .cfg_data(cfg_data_b), .config_en(config_en_b), .chain_tail_in(tail_b),
        .busy(busy_b), .done(done_b), .error(error_b)
    );

    // Chain models; flip_arm corrupts one bit of chain A during readback.
    logic [15:0] chain_a = 16'h0000;
    logic [11:0] chain_b = 12'h000;
    logic        flip_arm = 1'b0;
    int          en_seen_a = 0;

    always @(posedge clk) begin
        if (!flip_arm) en_seen_a <= 0;
        else if (config_en_a) en_seen_a <= en_seen_a + 1;
        if (config_en_a)
            chain_a <= {chain_a[14:0], cfg_data_a} ^
                       ((flip_arm && en_seen_a == 24) ? 16'h8000 : 16'h0000);
        if (config_en_b) chain_b <= {chain_b[10:0], cfg_data_b};
    end
    assign tail_a = chain_a[15];
    assign tail_b = chain_b[11];

    // Stream capture and activity counters, sampled mid-cycle.
    int cyc = 0;
    bit q_a[$];
    bit q_b[$];
    int idle_busy_a = 0, idle_busy_b = 0, ready_cyc_a = 0;
    int acc_a = 0, acc_b = 0;
    int last_en_a = 0, last_en_b = 0, done_rise_a = 0, done_rise_b = 0;
    logic pd_a = 1'b0, pd_b = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (config_en_a) begin q_a.push_back(cfg_data_a); last_en_a <= cyc; end
        else if (busy_a) idle_busy_a <= idle_busy_a + 1;
        if (config_en_b) begin q_b.push_back(cfg_data_b); last_en_b <= cyc; end
        else if (busy_b) idle_busy_b <= idle_busy_b + 1;
        if (word_ready_a) ready_cyc_a <= ready_cyc_a + 1;
        if (word_ready_a && word_valid) acc_a <= acc_a + 1;
        if (word_ready_b && word_valid) acc_b <= acc_b + 1;
        if (done_a && !pd_a) done_rise_a <= cyc;
        if (done_b && !pd_b) done_rise_b <= cyc;
        pd_a <= done_a;
        pd_b <= done_b;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (word_ready_a) begin ok = 1'b1; break; end
        end
    endtask

    // Reference: the chain receives the host words back to back, MSB first,
    // and keeps only the first len bits.
    function automatic logic [15:0] model_stream(input logic [7:0] w0, input logic [7:0] w1,
                                                 input int len);
        logic [15:0] cat;
        cat = {w0, w1};
        return cat >> (16 - len);
    endfunction

    task automatic run_load(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                            input int gap, input bit mid_start, input int abort_after,
                            input bit expect_err, input logic [15:0] exp_a,
                            input logic [11:0] exp_b);
        int qa0, qb0, iba0, ibb0, rc0, ac0, bc0;
        bit ok;
        logic [15:0] got_a;
        logic [11:0] got_b;
        qa0 = q_a.size(); qb0 = q_b.size();
        iba0 = idle_busy_a; ibb0 = idle_busy_b; rc0 = ready_cyc_a;
        ac0 = acc_a; bc0 = acc_b;
        start = 1'b1; word_in = w0; word_valid = 1'b1;
        tick();
        start = 1'b0;
        wait_ready(ok);
        chk({tag, "/ready0"}, 32'(ok), 32'd1);
        tick();
        word_in = w1;
        word_valid = (gap == 0);
        if (mid_start) begin start = 1'b1; tick(); start = 1'b0; end
        if (abort_after > 0) begin
            for (int i = 0; i < 40 && (q_a.size() - qa0) < abort_after; i++) begin
                @(negedge clk);
                #1;
            end
            @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk({tag, "/bits_before_rst"}, 32'(q_a.size() - qa0), 32'(abort_after));
            chk({tag, "/rst_en"}, 32'(config_en_a), 32'd0);
            chk({tag, "/rst_busy"}, 32'(busy_a), 32'd0);
            chk({tag, "/rst_done"}, 32'(done_a), 32'd0);
            chk({tag, "/rst_ready"}, 32'(word_ready_a), 32'd0);
            chk({tag, "/rst_b_en"}, 32'(config_en_b), 32'd0);
            word_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            tick();
            return;
        end
        if (gap > 0) begin
            wait_ready(ok);
            chk({tag, "/ready_gap"}, 32'(ok), 32'd1);
            repeat (gap) tick();
            word_valid = 1'b1;
        end
        wait_ready(ok);
        chk({tag, "/ready1"}, 32'(ok), 32'd1);
        tick();
        word_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_a && done_b) begin ok = 1'b1; break; end
        end
        chk({tag, "/done_timeout"}, 32'(ok), 32'd1);
        tick();
        got_a = 16'h0000;
        got_b = 12'h000;
        for (int i = 0; i < 16; i++)
            if (qa0 + i < q_a.size()) got_a = {got_a[14:0], q_a[qa0 + i]};
        for (int i = 0; i < 12; i++)
            if (qb0 + i < q_b.size()) got_b = {got_b[10:0], q_b[qb0 + i]};
        chk({tag, "/stream_a"}, 32'(got_a), 32'(exp_a));
        chk({tag, "/stream_b"}, 32'(got_b), 32'(exp_b));
        chk({tag, "/en_cnt_a"}, 32'(q_a.size() - qa0), 32'(16 * (1 + VER)));
        chk({tag, "/en_cnt_b"}, 32'(q_b.size() - qb0), 32'(12 * (1 + VER)));
        chk({tag, "/stall_a"}, 32'(idle_busy_a - iba0), 32'(1 + gap));
        chk({tag, "/stall_b"}, 32'(idle_busy_b - ibb0), 32'(1 + gap));
        chk({tag, "/accepts_a"}, 32'(acc_a - ac0), 32'd2);
        chk({tag, "/accepts_b"}, 32'(acc_b - bc0), 32'd2);
        if (gap == 0) chk({tag, "/ready_cycles"}, 32'(ready_cyc_a - rc0), 32'd2);
        chk({tag, "/done_lat_a"}, 32'(done_rise_a - last_en_a), 32'd1);
        chk({tag, "/done_lat_b"}, 32'(done_rise_b - last_en_b), 32'd1);
        chk({tag, "/done_busy"}, {29'd0, done_a, busy_a, word_ready_a}, 32'h4);
        chk({tag, "/done_en"}, 32'(config_en_a), 32'd0);
        chk({tag, "/error_a"}, 32'(error_a), 32'(expect_err));
        chk({tag, "/error_b"}, 32'(error_b), 32'd0);
        if (!expect_err) chk({tag, "/chain_a"}, 32'(chain_a), 32'(exp_a));
        chk({tag, "/chain_b"}, 32'(chain_b), 32'(exp_b));
    endtask

    typedef struct {
        logic [7:0]  w0;
        logic [7:0]  w1;
        int          gap;
        bit          mid_start;
        logic [15:0] exp_a;
        logic [11:0] exp_b;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] rw0, rw1;
        int rgap;
        vecs[0] = '{8'hA5, 8'h3C, 0, 1'b0, 16'hA53C, 12'hA53};
        vecs[1] = '{8'hA5, 8'h3C, 3, 1'b0, 16'hA53C, 12'hA53};
        vecs[2] = '{8'hFF, 8'h9F, 0, 1'b0, 16'hFF9F, 12'hFF9};
        vecs[3] = '{8'hA5, 8'h3C, 1, 1'b1, 16'hA53C, 12'hA53};
        vecs[4] = '{8'h00, 8'hFF, 2, 1'b0, 16'h00FF, 12'h00F};
        vecs[5] = '{8'h80, 8'h01, 0, 1'b1, 16'h8001, 12'h800};

        #1 rst_n = 1'b0;
        #10;
        chk("reset/ready", {30'd0, word_ready_a, word_ready_b}, 32'd0);
        chk("reset/en", {30'd0, config_en_a, config_en_b}, 32'd0);
        chk("reset/data", {30'd0, cfg_data_a, cfg_data_b}, 32'd0);
        chk("reset/busy", {30'd0, busy_a, busy_b}, 32'd0);
        chk("reset/done", {30'd0, done_a, done_b}, 32'd0);
        chk("reset/error", {30'd0, error_a, error_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("idle/busy", {30'd0, busy_a, busy_b}, 32'd0);

        for (int v = 0; v < 6; v++)
            run_load($sformatf("vec%0d", v), vecs[v].w0, vecs[v].w1, vecs[v].gap,
                     vecs[v].mid_start, 0, 1'b0, vecs[v].exp_a, vecs[v].exp_b);

        run_load("abort", 8'hA5, 8'h3C, 0, 1'b0, 5, 1'b0, 16'hA53C, 12'hA53);
        run_load("after_abort", 8'hA5, 8'h3C, 0, 1'b0, 0, 1'b0, 16'hA53C, 12'hA53);

        for (int r = 0; r < 6; r++) begin
            rw0 = 8'($urandom);
            rw1 = 8'($urandom);
            rgap = $urandom_range(0, 3);
            run_load($sformatf("rand%0d", r), rw0, rw1, rgap, 1'b0, 0, 1'b0,
                     model_stream(rw0, rw1, 16), 12'(model_stream(rw0, rw1, 12)));
        end

`ifdef CONFIG_LOADER_VERIFY_EN
        flip_arm = 1'b1;
        run_load("flip", 8'hA5, 8'h3C, 0, 1'b0, 0, 1'b1, 16'hA53C, 12'hA53);
        flip_arm = 1'b0;
        tick();
        run_load("post_flip", 8'h5A, 8'hC3, 0, 1'b0, 0, 1'b0, 16'h5AC3, 12'h5AC);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
